// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin scheduler sharing one mux4 data path among
// four valid/ready requesters, with a one-entry registered output stage.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid[3:0]      per-requester valid
//   req_data0..3        requester data words (W bits)
//   req_ready[3:0]      one-hot/zero transfer strobe (combinational from
//                       req_valid, out_ready and state)
//   out_valid           output register holds a word
//   out_data            registered selected word
//   out_src             index of the requester that supplied out_data
//   out_ready           downstream accepts out_data this cycle
// Optional (macro MUX4_ARB_STATS_EN):
//   stat_clr            clear all grant counters
//   grant_cnt[63:0]     four 16-bit saturating per-requester transfer counts
//
// Parameters: W (data width), BURST (1..15 transfers before priority rotates).

// Four-input data selector driven by the arbiter grant.
module mux4 #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [1:0]   s,
   output logic [W-1:0] y
);
   always_comb begin
      y = d0;
      case (s)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end
endmodule

module mux4_rr_arbiter #(
   parameter int unsigned W     = 4,
   parameter int unsigned BURST = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req_valid,
   input  logic [W-1:0] req_data0,
   input  logic [W-1:0] req_data1,
   input  logic [W-1:0] req_data2,
   input  logic [W-1:0] req_data3,
   output logic [3:0]   req_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   out_src,
   input  logic         out_ready
`ifdef MUX4_ARB_STATS_EN
   ,
   input  logic         stat_clr,
   output logic [63:0]  grant_cnt
`endif
);

   localparam int unsigned BW   = 4;
   localparam int unsigned NREQ = 4;

   // Arbitration state
   logic [1:0]    ptr_q,  ptr_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          hold_q, hold_d;
   logic [1:0]    hgnt_q, hgnt_d;

   // Selection signals
   logic          drop;
   logic          keep;
   logic [1:0]    scan_base;
   logic [1:0]    idx;
   logic [1:0]    gscan;
   logic          found;
   logic [1:0]    g;
   logic          cand;
   logic          free;
   logic          xfer;
   logic [BW-1:0] bcnt_new;
   logic [W-1:0]  mux_y;

   // Candidate selection: keep the held grantee, otherwise scan round-robin.
   // A grantee that dropped valid mid-burst rotates the scan this same cycle.
   always_comb begin
      drop      = hold_q && !req_valid[hgnt_q];
      keep      = hold_q && req_valid[hgnt_q] && (bcnt_q < BW'(BURST));
      scan_base = drop ? (hgnt_q + 2'd1) : ptr_q;
      idx       = '0;
      gscan     = '0;
      found     = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = scan_base + 2'(k);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gscan = idx;
         end
      end
      g    = keep ? hgnt_q : gscan;
      cand = keep || found;
   end

   assign free = !out_valid || out_ready;
   assign xfer = rst_n && cand && free;

   always_comb begin
      req_ready = 4'b0000;
      if (xfer) req_ready = 4'(4'b0001 << g);
   end

   mux4 #(.W(W)) u_mux (
      .d0 (req_data0),
      .d1 (req_data1),
      .d2 (req_data2),
      .d3 (req_data3),
      .s  (g),
      .y  (mux_y)
   );

   // Burst counting and priority rotation
   always_comb begin
      ptr_d    = ptr_q;
      bcnt_d   = bcnt_q;
      hold_d   = hold_q;
      hgnt_d   = hgnt_q;
      bcnt_new = keep ? (bcnt_q + BW'(1)) : BW'(1);
      if (xfer) begin
         bcnt_d = bcnt_new;
         if (bcnt_new >= BW'(BURST)) begin
            ptr_d  = g + 2'd1;
            hold_d = 1'b0;
         end else begin
            ptr_d  = scan_base;
            hold_d = 1'b1;
            hgnt_d = g;
         end
      end else if (free && drop) begin
         ptr_d  = hgnt_q + 2'd1;
         bcnt_d = '0;
         hold_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         bcnt_q    <= '0;
         hold_q    <= 1'b0;
         hgnt_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         ptr_q  <= ptr_d;
         bcnt_q <= bcnt_d;
         hold_q <= hold_d;
         hgnt_q <= hgnt_d;
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_src   <= g;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX4_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   // Saturating per-requester transfer counters; clear beats increment.
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         for (int i = 0; i < int'(NREQ); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (xfer && (g == 2'(i)) && (cnt_q[i] != 16'hFFFF))
               cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one BURST=1 and one BURST=3 instance
// share stimulus; a scoreboard queue holds the expected output words.
module tb_mux4_rr_arbiter;

   localparam int unsigned W = 4;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [W-1:0]  d0, d1, d2, d3;
   logic          out_ready;

   logic [3:0]    rr1, rr3;
   logic          ov1, ov3;
   logic [W-1:0]  od1, od3;
   logic [1:0]    os1, os3;

`ifdef MUX4_ARB_STATS_EN
   logic          stat_clr;
   logic [63:0]   gc1, gc3;
   initial stat_clr = 1'b0;
`endif

   logic          dsel;
   logic [3:0]    rr;
   logic          ov;
   logic [W-1:0]  od;
   logic [1:0]    os;

   typedef struct packed {
      logic [1:0]   src;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   compared;
   int   mismatched;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mux4_rr_arbiter #(.W(W), .BURST(1)) u1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data0 (d0),
      .req_data1 (d1),
      .req_data2 (d2),
      .req_data3 (d3),
      .req_ready (rr1),
      .out_valid (ov1),
      .out_data  (od1),
      .out_src   (os1),
      .out_ready (out_ready)
`ifdef MUX4_ARB_STATS_EN
      ,
      .stat_clr  (stat_clr),
      .grant_cnt (gc1)
`endif
   );

   mux4_rr_arbiter #(.W(W), .BURST(3)) u3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data0 (d0),
      .req_data1 (d1),
      .req_data2 (d2),
      .req_data3 (d3),
      .req_ready (rr3),
      .out_valid (ov3),
      .out_data  (od3),
      .out_src   (os3),
      .out_ready (out_ready)
`ifdef MUX4_ARB_STATS_EN
      ,
      .stat_clr  (stat_clr),
      .grant_cnt (gc3)
`endif
   );

   always_comb begin
      rr = dsel ? rr3 : rr1;
      ov = dsel ? ov3 : ov1;
      od = dsel ? od3 : od1;
      os = dsel ? os3 : os1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] dword(input int i);
      case (i)
         0:       return d0;
         1:       return d1;
         2:       return d2;
         default: return d3;
      endcase
   endfunction

   // One clock: drive inputs, check req_ready mid-cycle, check outputs after the edge.
   task automatic step(input string tag, input logic [3:0] v, input logic ordy,
                       input int exp_src, input logic exp_ov);
      exp_t       e;
      logic [3:0] exp_rr;
      req_valid = v;
      out_ready = ordy;
      exp_rr    = 4'b0000;
      if (exp_src >= 0) begin
         exp_rr = 4'(4'b0001 << exp_src);
         e.src  = 2'(exp_src);
         e.data = dword(exp_src);
         sb.push_back(e);
      end
      @(negedge clk);
      check({tag, ".req_ready"}, 32'(rr), 32'(exp_rr));
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 32'(ov), 32'(exp_ov));
      if (exp_src >= 0 && sb.size() > 0) last = sb.pop_front();
      if (exp_ov) begin
         check({tag, ".out_src"},  32'(os), 32'(last.src));
         check({tag, ".out_data"}, 32'(od), 32'(last.data));
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      req_valid = 4'hF;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check({tag, ".req_ready"}, 32'(rr), 32'h0);
      check({tag, ".out_valid"}, 32'(ov), 32'h0);
      check({tag, ".out_data"},  32'(od), 32'h0);
      check({tag, ".out_src"},   32'(os), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      last       = '0;
      dsel       = 1'b0;
      d0 = 4'd0; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3;
      rst_n = 1'b0;
      req_valid = 4'h0;
      out_ready = 1'b0;

      // BURST=1: reset, fairness, stall, sparse
      do_reset("rst1");
      step("fair0", 4'b1111, 1'b1, 0, 1'b1);
      step("fair1", 4'b1111, 1'b1, 1, 1'b1);
      step("fair2", 4'b1111, 1'b1, 2, 1'b1);
      step("fair3", 4'b1111, 1'b1, 3, 1'b1);
      step("fair4", 4'b1111, 1'b1, 0, 1'b1);
      step("fair5", 4'b1111, 1'b1, 1, 1'b1);
      step("drain1", 4'b0000, 1'b1, -1, 1'b0);

      d2 = 4'd5;
      step("pre_stall", 4'b1111, 1'b1, 2, 1'b1);
      step("stall0", 4'b1111, 1'b0, -1, 1'b1);
      step("stall1", 4'b1111, 1'b0, -1, 1'b1);
      step("stall2", 4'b1111, 1'b0, -1, 1'b1);
      step("unstall", 4'b1111, 1'b1, 3, 1'b1);
      step("sparse", 4'b0100, 1'b1, 2, 1'b1);
      step("drain2", 4'b0000, 1'b1, -1, 1'b0);
      step("idle", 4'b0000, 1'b0, -1, 1'b0);

      // BURST=3: bursts, rotation, mid-burst drop, mid-burst stall
      dsel = 1'b1;
      d2   = 4'd2;
      do_reset("rst3");
      step("b0", 4'b0011, 1'b1, 0, 1'b1);
      step("b1", 4'b0011, 1'b1, 0, 1'b1);
      step("b2", 4'b0011, 1'b1, 0, 1'b1);
      step("b3", 4'b0011, 1'b1, 1, 1'b1);
      step("b4", 4'b0011, 1'b1, 1, 1'b1);
      step("b5", 4'b0011, 1'b1, 1, 1'b1);
      step("b6", 4'b0011, 1'b1, 0, 1'b1);
      step("drop", 4'b0010, 1'b1, 1, 1'b1);
      step("b7", 4'b0011, 1'b1, 1, 1'b1);
      step("b8", 4'b0011, 1'b1, 1, 1'b1);
      step("b9", 4'b0011, 1'b1, 0, 1'b1);
      step("bstall", 4'b0011, 1'b0, -1, 1'b1);
      step("b10", 4'b0011, 1'b1, 0, 1'b1);
      step("drain3", 4'b0000, 1'b1, -1, 1'b0);

      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
